// File: rtl/zemina90_ctrl.sv
// -----------------------------------------------------------------------------
// zemina90_ctrl
//
// Controller for the Zemina 90-in-1 cartridge mapper. It holds the bank
// register written through I/O port 77h. Each CPU read in 4000h-BFFFh becomes
// one request/acknowledge fetch on the shared SDRAM port, and the CPU is held
// in wait until the byte comes back.
//
// Optional feature macro: ZEMINA90_READBACK_EN
//   When defined, an I/O read of port 77h returns bank_reg on cpu_data with
//   cpu_data_oe high, combinationally and with no wait state.
//   When undefined, I/O reads are ignored.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   enable       in   slot configured as Zemina 90; when low, new bus cycles are ignored
//   iorq/mreq    in   Z80 I/O and memory request strobes (active-high)
//   rd/wr        in   Z80 read and write strobes (active-high)
//   addr[15:0]   in   CPU address
//   data_in[7:0] in   CPU write data
//   bank_reg[7:0]out  current port 77h value
//   cpu_wait     out  CPU wait request
//   cpu_data[7:0]out  read data to CPU
//   cpu_data_oe  out  cpu_data valid / drive enable
//   mem_req      out  SDRAM read request
//   mem_addr[26:0] out SDRAM byte address (all-ones when idle)
//   mem_ack      in   one-cycle acknowledge, mem_data valid in the same cycle
//   mem_data[7:0]in   SDRAM read data
// -----------------------------------------------------------------------------
module zemina90_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        iorq,
    input  logic        mreq,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  bank_reg,
    output logic        cpu_wait,
    output logic [7:0]  cpu_data,
    output logic        cpu_data_oe,
    output logic        mem_req,
    output logic [26:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  bank_q;
    logic        io_wr_prev_q;
    logic        mem_rd_prev_q;
    logic        mem_req_q;
    logic [26:0] mem_addr_q;
    logic [7:0]  data_q;
    logic        oe_q;

    logic        io_wr_hit;
    logic        mem_rd_hit;
    logic        start;
    logic [5:0]  bank_d;
    logic        sub_d;
    logic [26:0] mem_addr_d;

    // Bus decodes. A mapped read is 4000h-BFFFh, i.e. A15 != A14.
    assign io_wr_hit  = enable & iorq & wr & (addr[7:0] == 8'h77);
    assign mem_rd_hit = enable & mreq & rd & (addr[15] ^ addr[14]);

    // Only a fresh read (rising edge of the decode) opens a transaction, and
    // only from IDLE. Gating with reset keeps cpu_wait low while reset is held
    // even if the CPU is still presenting a read.
    assign start = ~reset & mem_rd_hit & ~mem_rd_prev_q & (state_q == ST_IDLE);

    // Bank/sub-page selection from the current bank register and CPU address.
    always_comb begin
        bank_d = bank_q[5:0];
        sub_d  = addr[13];
        case (bank_q[7:6])
            2'b10: begin
                // 16KB-pair mode: low page in 4000h-7FFFh, high page above.
                bank_d = addr[15] ? (bank_q[5:0] | 6'h01) : (bank_q[5:0] & 6'h3E);
            end
            2'b11: begin
                // 8KB halves swapped in the 8000h-BFFFh window.
                sub_d = addr[13] ^ addr[15];
            end
            default: begin
                bank_d = bank_q[5:0];
                sub_d  = addr[13];
            end
        endcase
        mem_addr_d = {7'b0, bank_d, sub_d, addr[12:0]};
    end

    // Single FSM process; all memory-side outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bank_q        <= 8'h00;
            io_wr_prev_q  <= 1'b0;
            mem_rd_prev_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '1;
            data_q        <= 8'hFF;
            oe_q          <= 1'b0;
        end else begin
            io_wr_prev_q  <= io_wr_hit;
            mem_rd_prev_q <= mem_rd_hit;

            // The bank register may change at any time; an in-flight fetch
            // keeps the address latched at its start.
            if (io_wr_hit && !io_wr_prev_q) begin
                bank_q <= data_in;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= mem_addr_d;
                    end
                end
                ST_REQ: begin
                    // No exit on enable or strobes: the arbiter handshake
                    // always runs to completion once issued.
                    if (mem_ack) begin
                        state_q   <= ST_HOLD;
                        mem_req_q <= 1'b0;
                        data_q    <= mem_data;
                        oe_q      <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!rd || !mreq) begin
                        state_q    <= ST_IDLE;
                        oe_q       <= 1'b0;
                        data_q     <= 8'hFF;
                        mem_addr_q <= '1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_req_q  <= 1'b0;
                    oe_q       <= 1'b0;
                    data_q     <= 8'hFF;
                    mem_addr_q <= '1;
                end
            endcase
        end
    end

    assign bank_reg = bank_q;
    assign cpu_wait = start | (state_q == ST_REQ);
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef ZEMINA90_READBACK_EN
    logic io_rd_hit;
    assign io_rd_hit   = enable & iorq & rd & (addr[7:0] == 8'h77);
    assign cpu_data    = io_rd_hit ? bank_q : data_q;
    assign cpu_data_oe = io_rd_hit | oe_q;
`else
    assign cpu_data    = data_q;
    assign cpu_data_oe = oe_q;
`endif

endmodule

// File: tb/tb_zemina90_ctrl.sv
module tb_zemina90_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        iorq = 1'b0, mreq = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  bank_reg;
    logic        cpu_wait;
    logic [7:0]  cpu_data;
    logic        cpu_data_oe;
    logic        mem_req;
    logic [26:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    logic [26:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];

    zemina90_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable),
        .iorq(iorq), .mreq(mreq), .rd(rd), .wr(wr),
        .addr(addr), .data_in(data_in),
        .bank_reg(bank_reg), .cpu_wait(cpu_wait),
        .cpu_data(cpu_data), .cpu_data_oe(cpu_data_oe),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises a request or
    // presents read data.
    initial begin
        logic req_prev;
        logic oe_prev;
        logic [26:0] ea;
        logic [7:0]  ed;
        req_prev = 1'b0;
        oe_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !req_prev) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_addr), 32'h0);
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_mem_req: got request expected none");
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("mon_mem_addr", 32'(mem_addr), 32'(ea));
                end
            end
            if (cpu_data_oe && !oe_prev) begin
                if (exp_data_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_cpu_data_oe: got oe=1 data %h expected none", cpu_data);
                end else begin
                    ed = exp_data_q.pop_front();
                    chk("mon_cpu_data", 32'(cpu_data), 32'(ed));
                end
            end
            req_prev = mem_req;
            oe_prev  = cpu_data_oe;
        end
    end

    task automatic io_write(input logic [7:0] v);
        @(posedge clk); #1;
        iorq = 1'b1; wr = 1'b1; addr = 16'h0077; data_in = v;
        @(posedge clk); #1;
        iorq = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("bank_reg_after_out", 32'(bank_reg), 32'(v));
    endtask

    // One mapped read. ack_cyc is the cycle (counted from the start cycle 0)
    // in which mem_ack is pulsed. iow_cyc / en_drop_cyc < 0 disable the
    // optional mid-transaction port write / enable drop.
    task automatic mem_read(input logic [15:0] a, input int ack_cyc, input logic [7:0] d,
                            input logic [26:0] ea, input int iow_cyc, input logic [7:0] iow_val,
                            input int en_drop_cyc);
        int waits;
        logic got;
        exp_addr_q.push_back(ea);
        exp_data_q.push_back(d);
        @(posedge clk); #1;
        mreq = 1'b1; rd = 1'b1; addr = a;
        waits = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (c == ack_cyc) begin mem_ack = 1'b1; mem_data = d; end
            if (c == iow_cyc) begin iorq = 1'b1; wr = 1'b1; data_in = iow_val; end
            if (c == en_drop_cyc) enable = 1'b0;
            @(negedge clk);
            if (cpu_wait) waits++;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_data = 8'h00; iorq = 1'b0; wr = 1'b0;
            if (cpu_data_oe) got = 1'b1;
        end
        chk("data_returned", 32'(got), 32'd1);
        chk("wait_cycles", 32'(waits), 32'(ack_cyc + 1));
        @(negedge clk);
        chk("hold_mem_req", 32'(mem_req), 32'd0);
        chk("hold_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("hold_mem_addr", 32'(mem_addr), 32'(ea));
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_cpu_data", 32'(cpu_data), 32'(d));
        chk("hold_oe", 32'(cpu_data_oe), 32'd1);
        @(posedge clk); #1;
        mreq = 1'b0; rd = 1'b0; addr = 16'h0000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_oe", 32'(cpu_data_oe), 32'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'h7FFFFFF);
        enable = 1'b1;
    endtask

    task automatic no_req(input logic [15:0] a, input logic en);
        @(posedge clk); #1;
        enable = en; mreq = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        chk("noreq_cpu_wait", 32'(cpu_wait), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("noreq_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        mreq = 1'b0; rd = 1'b0; addr = 16'h0000; enable = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_bank_reg", 32'(bank_reg), 32'h00);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h7FFFFFF);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_cpu_data", 32'(cpu_data), 32'hFF);
        chk("rst_cpu_data_oe", 32'(cpu_data_oe), 32'd0);

        // bank 0: ack in cycle 3 -> four wait cycles
        mem_read(16'h4000, 3, 8'hA5, 27'h0000000, -1, 8'h00, -1);

        // bank 05h linear: sub = A13
        io_write(8'h05);
        mem_read(16'h6001, 1, 8'h3C, 27'h0016001, -1, 8'h00, -1);
        mem_read(16'hA001, 2, 8'h5A, 27'h0016001, -1, 8'h00, -1);

        // mode 10: even page low, odd page high
        io_write(8'h85);
        mem_read(16'h4000, 1, 8'h11, 27'h0010000, -1, 8'h00, -1);
        mem_read(16'h8000, 1, 8'h22, 27'h0014000, -1, 8'h00, -1);

        // mode 11: halves swapped at 8000h-BFFFh
        io_write(8'hC5);
        mem_read(16'h8000, 2, 8'h33, 27'h0016000, -1, 8'h00, -1);
        mem_read(16'hA000, 1, 8'h44, 27'h0014000, -1, 8'h00, -1);

        // unmapped regions and disabled slot
        no_req(16'h0000, 1'b1);
        no_req(16'hC000, 1'b1);
        no_req(16'h4000, 1'b0);

        // enable drops during REQ: fetch still completes (bank C5h, 4000h, sub 0)
        mem_read(16'h4000, 2, 8'h55, 27'h0014000, -1, 8'h00, 1);

        // port write during an in-flight fetch
        io_write(8'h05);
        mem_read(16'h4077, 4, 8'h66, 27'h0014077, 1, 8'h3F, -1);
        chk("bank_after_inflight_out", 32'(bank_reg), 32'h3F);
        mem_read(16'h4000, 1, 8'h77, 27'h00FC000, -1, 8'h00, -1);

        // I/O read of port 77h
`ifdef ZEMINA90_READBACK_EN
        exp_data_q.push_back(8'h3F);
`endif
        @(posedge clk); #1;
        iorq = 1'b1; rd = 1'b1; addr = 16'h0077;
        @(negedge clk);
`ifdef ZEMINA90_READBACK_EN
        chk("in77_cpu_data", 32'(cpu_data), 32'h3F);
        chk("in77_oe", 32'(cpu_data_oe), 32'd1);
`else
        chk("in77_oe", 32'(cpu_data_oe), 32'd0);
`endif
        chk("in77_wait", 32'(cpu_wait), 32'd0);
        @(posedge clk); #1;
        iorq = 1'b0; rd = 1'b0; addr = 16'h0000;
        @(posedge clk); #1;

        // asynchronous reset while in REQ
        exp_addr_q.push_back(27'h00FC000);
        mreq = 1'b1; rd = 1'b1; addr = 16'h4000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
        chk("pre_reset_cpu_wait", 32'(cpu_wait), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("reset_bank_reg", 32'(bank_reg), 32'h00);
        chk("reset_mem_addr", 32'(mem_addr), 32'h7FFFFFF);
        mreq = 1'b0; rd = 1'b0; addr = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("scoreboard_addr_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("scoreboard_data_empty", 32'(exp_data_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
